// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing monitor: coordinate recovery, line/frame measurement, lock detection.
// Optional per-frame CRC of delivered pixels is enabled by defining VGA_RX_CRC_EN.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 801,
  parameter int V_TOTAL     = 526,
  parameter int H_START     = 145,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 36,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1602
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        r,
  input  logic        g,
  input  logic        b,
  output logic        rx_de,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [2:0]  rx_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        err_hlen,
  output logic        err_vlen
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam int TO_BITS = $clog2(TIMEOUT + 1);
  localparam logic [TO_BITS-1:0] TO_MAX  = TO_BITS'(TIMEOUT);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [11:0] V_TOTAL_W = 12'(V_TOTAL);
  localparam logic [10:0] H_FIRST   = 11'(H_START);
  localparam logic [10:0] H_LAST    = 11'(H_START + H_ACTIVE - 1);
  localparam logic [10:0] V_FIRST   = 11'(V_START);
  localparam logic [10:0] V_LAST    = 11'(V_START + V_ACTIVE - 1);
  localparam logic [2:0]  LOCK_W    = 3'(LOCK_FRAMES);
  localparam logic [10:0] CNT_MAX   = 11'h7ff;

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  logic s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
  logic [2:0] s1_rgb_q;

  state_t             state_q;
  logic [10:0]        h_cnt_q, h_cnt_d;
  logic [10:0]        v_cnt_q, v_cnt_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]         good_cnt_q;
  logic               seen_hs_q, frame_bad_q;

  logic        rx_de_q, frame_start_q, locked_q, err_hlen_q, err_vlen_q;
  logic [9:0]  rx_x_q, rx_y_q;
  logic [2:0]  rx_rgb_q;
  logic [10:0] line_len_q, frame_lines_q;

  logic        hs_fall, vs_fall, checking, hlen_bad, vlen_bad, frame_bad_now;
  logic        timeout, in_window;
  logic [11:0] h_len, v_len;
  logic [2:0]  good_inc;

  // Two-stage input capture; s1 feeds all logic, s2 only supplies the previous level for edge detection.
  always_ff @(posedge dclk) begin
    if (rst) begin
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s2_hs_q  <= 1'b1;
      s2_vs_q  <= 1'b1;
      s1_rgb_q <= 3'b000;
    end else begin
      s1_hs_q  <= hs;
      s1_vs_q  <= vs;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s1_rgb_q <= {r, g, b};
    end
  end

  // Edge events, measurement comparisons and counter next-state values.
  always_comb begin
    hs_fall  = s2_hs_q & ~s1_hs_q;
    vs_fall  = s2_vs_q & ~s1_vs_q;
    h_len    = {1'b0, h_cnt_q} + 12'd1;
    v_len    = {1'b0, v_cnt_q} + 12'd1;
    checking = (state_q != ST_SEARCH);
    // A line is only measurable once a previous hs edge anchors its start.
    hlen_bad = hs_fall & seen_hs_q & checking & (h_len != H_TOTAL_W);
    vlen_bad = vs_fall & checking & (v_len != V_TOTAL_W);
    // The hs edge coinciding with vs closes the last line of the ending frame, so it counts against that frame.
    frame_bad_now = frame_bad_q | hlen_bad | vlen_bad;
    timeout  = ~hs_fall & (to_cnt_q == TO_LAST);
    good_inc = good_cnt_q + 3'd1;

    h_cnt_d = hs_fall ? 11'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 11'd1);
    if (vs_fall) begin
      v_cnt_d = 11'd0;
    end else if (hs_fall) begin
      v_cnt_d = (v_cnt_q == CNT_MAX) ? v_cnt_q : v_cnt_q + 11'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
    to_cnt_d = hs_fall ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);

    in_window = (h_cnt_q >= H_FIRST) && (h_cnt_q <= H_LAST) &&
                (v_cnt_q >= V_FIRST) && (v_cnt_q <= V_LAST);
  end

  // Counters, measurements, sticky errors and the SEARCH/MEASURE/LOCKED state machine.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      to_cnt_q      <= '0;
      good_cnt_q    <= '0;
      seen_hs_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      locked_q      <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_hlen_q    <= 1'b0;
      err_vlen_q    <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      to_cnt_q <= to_cnt_d;

      if (hs_fall) seen_hs_q <= 1'b1;
      if (hs_fall && seen_hs_q) line_len_q <= h_len[11] ? CNT_MAX : h_len[10:0];
      if (vs_fall) frame_lines_q <= v_len[11] ? CNT_MAX : v_len[10:0];
      if (hlen_bad) begin
        err_hlen_q  <= 1'b1;
        frame_bad_q <= 1'b1;
      end
      if (vlen_bad) err_vlen_q <= 1'b1;

      if (timeout) begin
        // Loss of hs: restart acquisition from scratch; error history is kept.
        state_q     <= ST_SEARCH;
        locked_q    <= 1'b0;
        good_cnt_q  <= '0;
        seen_hs_q   <= 1'b0;
        frame_bad_q <= 1'b0;
      end else if (vs_fall) begin
        frame_bad_q <= 1'b0;
        case (state_q)
          ST_SEARCH: begin
            state_q    <= ST_MEASURE;
            good_cnt_q <= '0;
          end
          ST_MEASURE: begin
            if (frame_bad_now) begin
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_inc;
              if (good_inc == LOCK_W) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (frame_bad_now) begin
              state_q    <= ST_MEASURE;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel outputs, registered one cycle behind the s1 sample they describe.
  always_ff @(posedge dclk) begin
    if (rst) begin
      rx_de_q       <= 1'b0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_rgb_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= vs_fall;
      rx_de_q       <= in_window & locked_q;
      if (in_window) begin
        rx_x_q   <= 10'(h_cnt_q - H_FIRST);
        rx_y_q   <= 10'(v_cnt_q - V_FIRST);
        rx_rgb_q <= locked_q ? s1_rgb_q : 3'b000;
      end else begin
        rx_x_q   <= '0;
        rx_y_q   <= '0;
        rx_rgb_q <= '0;
      end
    end
  end

  assign rx_de       = rx_de_q;
  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign rx_rgb      = rx_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_hlen    = err_hlen_q;
  assign err_vlen    = err_vlen_q;

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc_q, frame_crc_q;
  logic        crc_valid_q;

  // CRC-16-CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Accumulate a signature of every delivered pixel and publish it at each frame boundary while locked.
  always_ff @(posedge dclk) begin
    if (rst) begin
      crc_acc_q   <= 16'hffff;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      if (vs_fall) begin
        if (locked_q) begin
          frame_crc_q <= crc_acc_q;
          crc_valid_q <= 1'b1;
        end
        crc_acc_q <= 16'hffff;
      end else if (rx_de_q) begin
        crc_acc_q <= crc16_byte(crc_acc_q, {5'b00000, rx_rgb_q});
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - scoreboard testbench for vga_rx_monitor using a reduced raster.
module tb_vga_rx_monitor;

  localparam int H_TOTAL  = 40;
  localparam int V_TOTAL  = 20;
  localparam int H_START  = 10;
  localparam int H_ACTIVE = 20;
  localparam int V_START  = 4;
  localparam int V_ACTIVE = 10;
  localparam int LOCK_FR  = 2;
  localparam int TIMEOUT  = 80;
  localparam int HS_LOW   = 4;
  localparam int VS_LOW   = 2;

  logic        dclk = 1'b0;
  logic        rst, hs, vs, r, g, b;
  logic        rx_de, frame_start, locked, err_hlen, err_vlen;
  logic [9:0]  rx_x, rx_y;
  logic [2:0]  rx_rgb;
  logic [10:0] line_len, frame_lines;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_vs = 0;
  int n_fs = 0;
  logic [22:0] sb_q[$];

  vga_rx_monitor #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_START(V_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FR), .TIMEOUT(TIMEOUT)
  ) dut (
    .dclk(dclk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .rx_de(rx_de), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
    .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines),
    .err_hlen(err_hlen), .err_vlen(err_vlen)
`ifdef VGA_RX_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  always #5 dclk = ~dclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  always @(negedge dclk) begin
    if (frame_start === 1'b1) n_fs++;
    if (rx_de === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pixel", {rx_x, rx_y, rx_rgb}, 23'h7fffff);
      end else begin
        check("pixel", {rx_x, rx_y, rx_rgb}, sb_q.pop_front());
      end
    end else begin
      check("rgb_idle", rx_rgb, 3'b000);
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_prev;
  bit          crc_seen = 1'b0;
  // Every locked frame carries the same picture, so every published CRC must match.
  always @(negedge dclk) begin
    if (crc_valid === 1'b1) begin
      if (crc_seen) check("crc_repeat", frame_crc, crc_prev);
      crc_prev = frame_crc;
      crc_seen = 1'b1;
    end
  end
`endif

  // One full frame. lb/la: locked expected one and two cycles after the vs edge.
  // ll/fl/eh/ev: expected line_len, frame_lines, err_hlen, err_vlen shortly after that edge (-1 skips).
  task automatic run_frame(input int lines, input int short_ln, input int rst_ln,
                           input int lb, input int la, input int ll, input int fl,
                           input int eh, input int ev);
    logic [2:0] rgb;
    logic [9:0] x, y;
    bit         in_win;
    n_vs++;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < ((l == short_ln) ? H_TOTAL - 1 : H_TOTAL); c++) begin
        @(negedge dclk);
        if (l == 0 && c == 1) check("locked_before", locked, lb);
        if (l == 0 && c == 2) begin
          check("locked_after", locked, la);
          if (ll >= 0) check("line_len", line_len, ll);
          if (fl >= 0) check("frame_lines", frame_lines, fl);
          if (eh >= 0) check("err_hlen", err_hlen, eh);
          if (ev >= 0) check("err_vlen", err_vlen, ev);
        end
        if (short_ln >= 0 && l == short_ln + 1 && c == 2) begin
          check("short_line_len", line_len, H_TOTAL - 1);
          check("short_err_hlen", err_hlen, 1);
          check("short_locked", locked, 1);
        end
        if (l == rst_ln && c == 20) begin
          rst = 1'b1;
          @(negedge dclk);
          check("rst_outputs", {rx_de, rx_x, rx_y, rx_rgb, frame_start, locked,
                                line_len, frame_lines, err_hlen, err_vlen}, '0);
          rst = 1'b0;
          hs = 1'b1; vs = 1'b1; {r, g, b} = 3'b000;
          sb_q.delete();
          return;
        end
        hs = (c < HS_LOW) ? 1'b0 : 1'b1;
        vs = (l < VS_LOW) ? 1'b0 : 1'b1;
        in_win = (c >= H_START + 1) && (c <= H_START + H_ACTIVE) &&
                 (l >= V_START) && (l < V_START + V_ACTIVE);
        x = 10'(c - 1 - H_START);
        y = 10'(l - V_START);
        rgb = in_win ? 3'(x + y + 10'd7) : 3'b000;
        {r, g, b} = rgb;
        if (in_win && la == 1) sb_q.push_back({x, y, rgb});
      end
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; r = 1'b0; g = 1'b0; b = 1'b0;
    repeat (3) @(negedge dclk);
    check("reset_outputs", {rx_de, rx_x, rx_y, rx_rgb, frame_start, locked,
                            line_len, frame_lines, err_hlen, err_vlen}, '0);
    rst = 1'b0;
    repeat (5) @(negedge dclk);

    //        lines short rst lb la  ll  fl  eh  ev
    run_frame(20, -1, -1, 0, 0,  0, -1,  0,  0);
    run_frame(20, -1, -1, 0, 0, 40, 20,  0,  0);
    run_frame(20, -1, -1, 0, 1, 40, 20,  0,  0);
    run_frame(20, -1, -1, 1, 1, 40, 20,  0,  0);
    run_frame(20,  7, -1, 1, 1, 40, 20,  0,  0);
    run_frame(20, -1, -1, 1, 0, 40, 20,  1,  0);
    run_frame(20, -1, -1, 0, 0, 40, 20,  1,  0);
    run_frame(20, -1, -1, 0, 1, -1, -1, -1, -1);
    run_frame(19, -1, -1, 1, 1, 40, 20,  1,  0);
    run_frame(20, -1, -1, 1, 0, 40, 19,  1,  1);
    run_frame(20, -1, -1, 0, 0, 40, 20,  1,  1);
    run_frame(20, -1, -1, 0, 1, -1, -1, -1, -1);

    hs = 1'b1; vs = 1'b1; {r, g, b} = 3'b000;
    repeat (TIMEOUT + 10) @(negedge dclk);
    check("timeout_locked", locked, 0);
    check("timeout_rx_de", rx_de, 0);
    check("timeout_errs", {err_hlen, err_vlen}, 2'b11);

    run_frame(20, -1, -1, 0, 0, -1, -1, -1, -1);
    run_frame(20, -1, -1, 0, 0, 40, 20,  1,  1);
    run_frame(20, -1,  6, 0, 1, 40, 20,  1,  1);
    run_frame(20, -1, -1, 0, 0,  0, -1,  0,  0);
    run_frame(20, -1, -1, 0, 0, 40, 20,  0,  0);
    run_frame(20, -1, -1, 0, 1, 40, 20,  0,  0);

    hs = 1'b1; vs = 1'b1; {r, g, b} = 3'b000;
    repeat (10) @(negedge dclk);
    check("scoreboard_empty", sb_q.size(), 0);
    check("frame_start_count", n_fs, n_vs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: samples hs/vs/r/g/b at the panel end, recovers pixel coordinates, and checks timing.
- Reconstructs rx_x/rx_y/rx_de/rx_rgb, measures line length and lines per frame, and declares lock after consecutive conforming frames.
- Used as an on-chip self-test/loopback checker and as a capture front-end for a frame-compare block.

Parameters:
- H_TOTAL, 801, expected dclk cycles between hs falling edges
- V_TOTAL, 526, expected hs falling edges between vs falling edges
- H_START, 145, h_cnt value of first active pixel
- H_ACTIVE, 640, active pixels per line
- V_START, 36, v_cnt value of first active line
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames needed for lock (1..7)
- TIMEOUT, 1602, dclk cycles without an hs falling edge before returning to SEARCH

Ports:
- dclk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high; clock dclk
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- r, g, b  in  1 each  pixel colour
- rx_de  out  1  active pixel strobe (only while locked)
- rx_x  out  10  pixel column, 0..H_ACTIVE-1
- rx_y  out  10  pixel row, 0..V_ACTIVE-1
- rx_rgb  out  3  {r,g,b} aligned with rx_de; 0 when rx_de=0
- frame_start  out  1  one-cycle pulse on each vs falling edge
- locked  out  1  timing locked
- line_len  out  11  last measured line length
- frame_lines  out  11  last measured lines per frame
- err_hlen  out  1  sticky: a line length differed from H_TOTAL
- err_vlen  out  1  sticky: a frame line count differed from V_TOTAL

Behaviour:
- Input stage: hs, vs, r, g, b registered once (s1), then again (s2). Falling edge = s2 high and s1 low. All logic acts on s1.
- Reset values: all outputs 0; FSM=SEARCH; h_cnt, v_cnt, good_cnt, to_cnt = 0; s1/s2 hs,vs = 1.
- h_cnt (11 b):
  - 0 on an hs fall cycle, else +1, saturating at 2047.
  - On each hs fall with a prior hs fall seen since SEARCH: line_len <= h_cnt+1.
  - If h_cnt+1 != H_TOTAL: err_hlen <= 1 and the current frame is marked bad.
- v_cnt (11 b):
  - +1 on each hs fall.
  - On a vs fall: frame_lines <= v_cnt+1; v_cnt <= 0.
  - Simultaneous hs and vs fall: that hs edge is line 0 of the new frame (v_cnt <= 0, not 1); frame_lines still captures v_cnt+1.
  - If the captured count != V_TOTAL: err_vlen <= 1 and the frame is bad.
- frame_start pulses on every vs fall, in every state.
- FSM:
  - SEARCH: wait for a vs fall -> MEASURE, good_cnt=0, frame-bad flag cleared. Line and frame checks are suppressed in this state.
  - MEASURE, at each vs fall: good frame -> good_cnt+1, and when it reaches LOCK_FRAMES go to LOCKED with locked=1 on the next cycle; bad frame -> good_cnt=0, stay. Frame-bad flag is cleared at every vs fall.
  - LOCKED, at each vs fall: bad frame -> MEASURE, locked=0, good_cnt=0.
  - Any state: to_cnt counts cycles since the last hs fall. Reaching TIMEOUT -> SEARCH, locked=0; err flags unchanged.
- Sticky error flags clear only on rst.
- Active window: h_cnt in [H_START, H_START+H_ACTIVE-1] and v_cnt in [V_START, V_START+V_ACTIVE-1].
- Outputs in the active window are registered and valid one cycle after the s1 sample:
  - rx_de = window AND locked
  - rx_x = h_cnt-H_START
  - rx_y = v_cnt-V_START
  - rx_rgb = s1 rgb
- Outside the window: rx_x, rx_y hold 0 and rx_rgb = 0.
- rst mid-frame: everything returns to reset values next cycle. The next lock needs a fresh vs fall plus LOCK_FRAMES good frames.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- Defined:
  - Adds outputs frame_crc[15:0] and crc_valid.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) is run over the 3-bit rx_rgb, zero-extended to 8 bits, for every rx_de cycle.
  - On each vs fall while locked: frame_crc latches the result, crc_valid pulses for 1 cycle, and the accumulator re-inits.
  - Reset: frame_crc=0, crc_valid=0.
- Undefined: no ports and no logic; behaviour otherwise identical.

Test Plan:
- Nominal stimulus (801-cycle lines, 96-cycle hs low, 526-line frames, 2-line vs low, hs/vs falling together) -> locked=1 one cycle after the 3rd vs fall; line_len=801, frame_lines=526; no errors.
- Locked, data pixel 7 at column 0 row 0 -> rx_de=1 with rx_x=0, rx_y=0, rx_rgb=3'b111. Last pixel of the line -> rx_x=639. Row 479 seen, row 480 never seen.
- One 800-cycle line mid-frame while locked -> err_hlen=1; locked drops at the next vs fall; relock after 2 further good frames.
- Frame with 525 lines -> frame_lines=525, err_vlen=1, good_cnt reset.
- hs held high for 1602 cycles -> SEARCH, locked=0, rx_de=0. Also: rst asserted mid-line -> all outputs 0 next cycle.
- VGA_RX_CRC_EN, constant rgb=0 frame -> crc_valid pulse with a deterministic frame_crc that repeats across consecutive frames. One pixel flipped -> different value.
